// File: rtl/encoder8to3_queue_if.sv
// rtl/encoder8to3_queue_if.sv - request/index handshake bundle for encoder8to3_queue
interface encoder8to3_queue_if;
  logic       req_valid;
  logic [7:0] data_in;
  logic       ready_in;
  logic [2:0] y_out;
  logic       valid_out;
  logic [7:0] pending_out;
  logic       dup_out;
  logic       idle_out;

  modport master (
    output req_valid, data_in, ready_in,
    input  y_out, valid_out, pending_out, dup_out, idle_out
  );

  modport slave (
    input  req_valid, data_in, ready_in,
    output y_out, valid_out, pending_out, dup_out, idle_out
  );
endinterface

// File: rtl/encoder8to3_queue.sv
// rtl/encoder8to3_queue.sv - pending-register 8-to-3 encoder with valid/ready output
// Optional rotating priority enabled by defining ENCODER_ROUND_ROBIN_EN.
module encoder8to3_queue (
  input  logic                clk,
  input  logic                rst,
  encoder8to3_queue_if.slave  bus
);

  logic [7:0] r_pending;
  logic [2:0] r_y;
  logic       r_valid;
  logic       r_dup;

  logic       w_free;
  logic       w_load;
  logic [2:0] w_sel;
  logic [7:0] w_served;
  logic [7:0] w_new;

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [2:0] r_rr;
  logic [2:0] w_idx;
  logic       w_hit;

  // Search upward from the slot after the last served index, wrapping 7 -> 0.
  always_comb begin
    w_sel = 3'd0;
    w_idx = 3'd0;
    w_hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w_idx = r_rr + 3'(k) + 3'd1;
      if (!w_hit && r_pending[w_idx]) begin
        w_sel = w_idx;
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= 3'd7;
    end else if (w_load) begin
      r_rr <= w_sel;
    end
  end
`else
  always_comb begin
    w_sel = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (r_pending[k]) w_sel = 3'(k);
    end
  end
`endif

  assign w_free   = !r_valid || bus.ready_in;
  assign w_load   = w_free && (r_pending != 8'd0);
  assign w_served = w_load ? (8'd1 << w_sel) : 8'd0;
  assign w_new    = bus.req_valid ? bus.data_in : 8'd0;

  // A request landing on the bit served this cycle re-arms it for a later emission.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 8'd0;
      r_y       <= 3'd0;
      r_valid   <= 1'b0;
      r_dup     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_served) | w_new;
      r_dup     <= |(w_new & r_pending & ~w_served);
      if (w_load) begin
        r_y     <= w_sel;
        r_valid <= 1'b1;
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.y_out       = r_y;
  assign bus.valid_out   = r_valid;
  assign bus.pending_out = r_pending;
  assign bus.dup_out     = r_dup;
  assign bus.idle_out    = (r_pending == 8'd0) && !r_valid;

endmodule
